// File: rtl/i4001.sv
// i4001: ROM and I/O port responder on the MCS-4 4-bit system bus.
//
// Follows the CPU's 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3),
// captures the 12-bit fetch address, drives the selected instruction byte in
// M1/M2, and implements SRC chip selection with WRR/RDR on a 4-bit I/O port.
// Program memory is loaded through a side write port.
//
// Parameters:
//   CHIP_ID   chip number matched against the A3 nibble and the SRC high nibble
//   IO_MASK   per-bit port direction, 1 = input, 0 = output
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sync                  high during X3, from the CPU
//   cm_rom                ROM command line, from the CPU
//   dbus_in  [3:0]        resolved system bus
//   dbus_out [3:0]        this chip's bus drive, 0 when idle (registered)
//   io_in    [3:0]        external port pins
//   io_out   [3:0]        output-port latch, input bits always 0
//   prog_we, prog_addr, prog_data   program-memory write port
module i4001 #(
    parameter logic [3:0] CHIP_ID = 4'h0,
    parameter logic [3:0] IO_MASK = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    input  logic       cm_rom,
    input  logic [3:0] dbus_in,
    output logic [3:0] dbus_out,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    input  logic       prog_we,
    input  logic [7:0] prog_addr,
    input  logic [7:0] prog_data
);

    localparam logic [2:0] PH_A1 = 3'd0;
    localparam logic [2:0] PH_A2 = 3'd1;
    localparam logic [2:0] PH_A3 = 3'd2;
    localparam logic [2:0] PH_M1 = 3'd3;
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X1 = 3'd5;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    localparam logic [3:0] OPA_WRR = 4'h2;
    localparam logic [3:0] OPA_RDR = 4'hA;

    logic [7:0] r_mem [256];

    logic [2:0] r_phase;
    logic       r_synced;
    logic [3:0] r_addr_lo;
    logic [3:0] r_addr_mid;
    logic       r_rom_sel;
    logic [7:0] r_byte;
    logic       r_io_instr;
    logic [3:0] r_io_opa;
    logic       r_src_sel;
    logic [3:0] r_io_out;
    logic [3:0] r_io_s1;
    logic [3:0] r_io_s2;
    logic [3:0] r_dbus_out;

    logic [2:0] w_phase_nxt;
    logic       w_rom_hit;
    logic [7:0] w_fetch;
    logic [3:0] w_rdr_val;
    logic [3:0] w_dbus_nxt;

    assign dbus_out = r_dbus_out;
    assign io_out   = r_io_out;

    // sync in any subcycle forces the next one to be A1.
    assign w_phase_nxt = sync ? PH_A1 : r_phase + 3'd1;
    assign w_rom_hit   = cm_rom && (dbus_in == CHIP_ID);
    assign w_fetch     = r_mem[{r_addr_mid, r_addr_lo}];
    assign w_rdr_val   = (r_io_s2 & IO_MASK) | (r_io_out & ~IO_MASK);

    // Program memory; not reset. A write at the A3 edge lands after the read.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Bus drive for the cycle about to begin. A pending drive is dropped
    // whenever the next cycle is A1, which also covers a mid-cycle sync.
    always_comb begin
        w_dbus_nxt = 4'h0;
        if (r_synced) begin
            case (w_phase_nxt)
                PH_M1: if (w_rom_hit) w_dbus_nxt = w_fetch[7:4];
                PH_M2: if (r_rom_sel) w_dbus_nxt = r_byte[3:0];
                PH_X2: begin
                    if (r_io_instr && r_src_sel && (r_io_opa == OPA_RDR)) begin
                        w_dbus_nxt = w_rdr_val;
                    end
                end
                default: w_dbus_nxt = 4'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase    <= PH_A1;
            r_synced   <= 1'b0;
            r_addr_lo  <= 4'h0;
            r_addr_mid <= 4'h0;
            r_rom_sel  <= 1'b0;
            r_byte     <= 8'h00;
            r_io_instr <= 1'b0;
            r_io_opa   <= 4'h0;
            r_src_sel  <= 1'b0;
            r_io_out   <= 4'h0;
            r_io_s1    <= 4'h0;
            r_io_s2    <= 4'h0;
            r_dbus_out <= 4'h0;
        end else begin
            r_phase    <= w_phase_nxt;
            r_dbus_out <= w_dbus_nxt;
            r_io_s1    <= io_in;
            r_io_s2    <= r_io_s1;
            if (sync) begin
                r_synced <= 1'b1;
            end

            case (r_phase)
                PH_A1: r_addr_lo  <= dbus_in;
                PH_A2: r_addr_mid <= dbus_in;
                PH_A3: begin
                    r_rom_sel <= w_rom_hit;
                    r_byte    <= w_fetch;
                end
                PH_M2: begin
                    if (cm_rom) begin
                        r_io_instr <= 1'b1;
                        r_io_opa   <= dbus_in;
                    end
                end
                PH_X2: begin
                    // Protocol state is meaningless before the first sync.
                    if (r_synced) begin
                        if (cm_rom && !r_io_instr) begin
                            r_src_sel <= (dbus_in == CHIP_ID);
                        end
                        if (r_io_instr && r_src_sel && (r_io_opa == OPA_WRR)) begin
                            r_io_out <= dbus_in & ~IO_MASK;
                        end
                    end
                end
                PH_M1, PH_X1, PH_X3: ;
                default: ;
            endcase

            // Leaving for A1 ends the I/O instruction, even on an early sync.
            if (w_phase_nxt == PH_A1) begin
                r_io_instr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i4001.sv
// Directed testbench for i4001 (CHIP_ID=2, IO_MASK=4'b0011).
// Each instruction cycle is observed as a 32-bit word: nibble i holds
// dbus_out during subcycle i (0=A1 ... 7=X3).
module tb_i4001;

    logic       clk = 1'b0;
    logic       rst;
    logic       sync;
    logic       cm_rom;
    logic [3:0] dbus_in;
    logic [3:0] dbus_out;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;

    int errors = 0;
    int checks = 0;

    // Optional program write placed in the A3 subcycle of the next instr().
    logic       pw_a3 = 1'b0;
    logic [7:0] pw_addr = 8'h00;
    logic [7:0] pw_data = 8'h00;

    i4001 #(
        .CHIP_ID(4'h2),
        .IO_MASK(4'b0011)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .cm_rom   (cm_rom),
        .dbus_in  (dbus_in),
        .dbus_out (dbus_out),
        .io_in    (io_in),
        .io_out   (io_out),
        .prog_we  (prog_we),
        .prog_addr(prog_addr),
        .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    // One subcycle: record dbus_out for this cycle, drive inputs, pass the edge.
    task automatic step(input logic s, input logic cm, input logic [3:0] d,
                        output logic [3:0] obs);
        obs     = dbus_out;
        sync    = s;
        cm_rom  = cm;
        dbus_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                         input logic cm3, input logic cmm2, input logic [3:0] m2d,
                         input logic cmx2, input logic [3:0] x2d, input logic endsync,
                         output logic [31:0] obs);
        logic [3:0] o;
        step(1'b0, 1'b0, a1, o);    obs[3:0]   = o;
        step(1'b0, 1'b0, a2, o);    obs[7:4]   = o;
        prog_we   = pw_a3;
        prog_addr = pw_addr;
        prog_data = pw_data;
        step(1'b0, cm3, a3, o);     obs[11:8]  = o;
        prog_we   = 1'b0;
        step(1'b0, 1'b0, 4'h0, o);  obs[15:12] = o;
        step(1'b0, cmm2, m2d, o);   obs[19:16] = o;
        step(1'b0, 1'b0, 4'h0, o);  obs[23:20] = o;
        step(1'b0, cmx2, x2d, o);   obs[27:24] = o;
        step(endsync, 1'b0, 4'h0, o); obs[31:28] = o;
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; dbus_in = 4'h0; io_in = 4'h0;
        prog_we = 1'b0; prog_addr = 8'h00; prog_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (dbus_out !== 4'h0) begin
            errors++; $display("FAIL reset_dbus: got %h want 0", dbus_out);
        end
        checks++;
        if (io_out !== 4'h0) begin
            errors++; $display("FAIL reset_io_out: got %h want 0", io_out);
        end
    endtask

    task automatic test_fetch();
        logic [31:0] obs;
        logic [3:0]  o;
        step(1'b1, 1'b0, 4'h0, o);  // first sync, next cycle is A1
        instr(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0005_A000) begin
            errors++; $display("FAIL fetch_hit: got %h want 0005a000", obs);
        end
        instr(4'h4, 4'h3, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0) begin
            errors++; $display("FAIL fetch_miss_id: got %h want 0", obs);
        end
        instr(4'h4, 4'h3, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0) begin
            errors++; $display("FAIL fetch_miss_cm: got %h want 0", obs);
        end
        instr(4'hF, 4'h7, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h000C_3000) begin
            errors++; $display("FAIL fetch_hit_7f: got %h want 000c3000", obs);
        end
    endtask

    task automatic test_io();
        logic [31:0] obs;
        io_in = 4'b0101;
        // SRC to this chip (fetch itself addressed elsewhere)
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h2, 1'b1, obs);
        checks++;
        if (obs !== 32'h0) begin
            errors++; $display("FAIL src_drive: got %h want 0", obs);
        end
        checks++;
        if (io_out !== 4'b0000) begin
            errors++; $display("FAIL src_io_out: got %b want 0000", io_out);
        end
        // WRR with data F
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 4'hF, 1'b1, obs);
        checks++;
        if (io_out !== 4'b1100) begin
            errors++; $display("FAIL wrr_io_out: got %b want 1100", io_out);
        end
        // RDR
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0D00_0000) begin
            errors++; $display("FAIL rdr_drive: got %h want 0d000000", obs);
        end
        // Foreign SRC, then WRR 0 and RDR must be ignored
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1, obs);
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (io_out !== 4'b1100) begin
            errors++; $display("FAIL foreign_wrr: got %b want 1100", io_out);
        end
        instr(4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0) begin
            errors++; $display("FAIL foreign_rdr: got %h want 0", obs);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs;
        logic [3:0]  o;
        step(1'b0, 1'b0, 4'h4, o);
        step(1'b0, 1'b0, 4'h3, o);
        step(1'b0, 1'b1, 4'h2, o);
        checks++;
        if (dbus_out !== 4'hA) begin
            errors++; $display("FAIL rst_pre_m1: got %h want a", dbus_out);
        end
        rst = 1'b1;
        step(1'b0, 1'b0, 4'h0, o);
        rst = 1'b0;
        checks++;
        if (dbus_out !== 4'h0) begin
            errors++; $display("FAIL rst_after: got %h want 0", dbus_out);
        end
        // No sync seen yet: a would-be hit must stay silent
        instr(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0) begin
            errors++; $display("FAIL rst_unsynced: got %h want 0", obs);
        end
        instr(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0005_A000) begin
            errors++; $display("FAIL rst_resume: got %h want 0005a000", obs);
        end
    endtask

    task automatic test_resync();
        logic [31:0] obs;
        logic [3:0]  o;
        step(1'b0, 1'b0, 4'h4, o);
        step(1'b0, 1'b0, 4'h3, o);
        step(1'b0, 1'b1, 4'h2, o);
        step(1'b0, 1'b0, 4'h0, o);
        checks++;
        if (o !== 4'hA) begin
            errors++; $display("FAIL resync_m1: got %h want a", o);
        end
        step(1'b1, 1'b0, 4'h0, o);  // early sync in M2
        checks++;
        if (o !== 4'h5) begin
            errors++; $display("FAIL resync_m2: got %h want 5", o);
        end
        instr(4'hF, 4'h7, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h000C_3000) begin
            errors++; $display("FAIL resync_fetch: got %h want 000c3000", obs);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] obs;
        pw_a3   = 1'b1;
        pw_addr = 8'h34;
        pw_data = 8'h96;
        instr(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        pw_a3   = 1'b0;
        checks++;
        if (obs !== 32'h0005_A000) begin
            errors++; $display("FAIL we_race_old: got %h want 0005a000", obs);
        end
        instr(4'h4, 4'h3, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1, obs);
        checks++;
        if (obs !== 32'h0006_9000) begin
            errors++; $display("FAIL we_race_new: got %h want 00069000", obs);
        end
    endtask

    initial begin
        test_reset();
        load(8'h34, 8'hA5);
        load(8'h7F, 8'h3C);
        test_fetch();
        test_io();
        test_reset_mid();
        test_resync();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
